// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter time-sharing one WIDTH-bit adder among N_REQ requesters.
// Latency: one cycle from the transfer edge to a registered sum on out_sum.
// Backpressure: a held result (out_valid && !out_ready) blocks every grant.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   out_valid/ready     result handshake toward the consumer
//   out_sum, out_carry  registered (a+b) mod 2^WIDTH and carry out
//   out_id              requester that produced the current result
//   state               IDLE=0, FULL=1, HOLD=2
module shared_adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 3,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_sum,
  output logic                   out_carry,
  output logic [ID_W-1:0]        out_id,
  output logic [1:0]             state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic             can_accept;
  logic             transfer;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH:0]   sum_next;
  int               scan;

  // The state is a pure decode of the result register and the consumer's
  // ready, so it never disagrees with the handshake it describes.
  always_comb begin
    if (!out_valid)     state = ST_IDLE;
    else if (out_ready) state = ST_FULL;
    else                state = ST_HOLD;
  end

  // out_ready only matters while a result is held.
  assign can_accept = !out_valid || out_ready;

  // Scan from rr_ptr upward, wrapping modulo N_REQ; first valid wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!gnt_found && req_valid[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(scan);
      end
    end
  end

  assign transfer = gnt_found && can_accept;

  // Reset masks the grant so nothing is acknowledged during the reset cycle.
  always_comb begin
    req_ready = '0;
    if (transfer && !reset) req_ready[gnt_idx] = 1'b1;
  end

  // Operand mux driven by the grant index, feeding the single shared adder.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_next = {1'b0, sel_a} + {1'b0, sel_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (transfer) begin
        // A pop in the same cycle is absorbed here: the register reloads
        // and out_valid stays high, giving one add per cycle.
        out_valid <= 1'b1;
        out_sum   <= sum_next[WIDTH-1:0];
        out_carry <= sum_next[WIDTH];
        out_id    <= gnt_idx;
        rr_ptr    <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_valid && out_ready) begin
        // Pop only: data fields keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
